// File: rtl/tlut_product_bank_if.sv
// Product bank bus: upstream beat handshake, downstream frame handshake and
// the frame payload.
//   master : upstream/downstream side (drives beats and out_ready)
//   slave  : the product bank (drives in_ready, frame outputs, frame_cnt)
interface tlut_product_bank_if #(
   parameter int DIM_C     = 4,
   parameter int DIM_A     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 16
);
   logic                                         in_valid;
   logic                                         in_ready;
   logic [DIM_C-1:0][ACC_WIDTH-1:0]              in_data;
   logic [DIM_A-1:0]                             in_enable;
   logic                                         in_last;
   logic                                         acc_mode;
   logic                                         out_valid;
   logic                                         out_ready;
   logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]   out_data;
   logic [DIM_A-1:0]                             out_mask;
   logic [CNT_WIDTH-1:0]                         frame_cnt;

   modport master (
      output in_valid, in_data, in_enable, in_last, acc_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mask, frame_cnt
   );

   modport slave (
      input  in_valid, in_data, in_enable, in_last, acc_mode, out_ready,
      output in_ready, out_valid, out_data, out_mask, frame_cnt
   );
endinterface

// File: rtl/tlut_product_bank.sv
// Product capture bank for the temporal-LUT multiplier datapath.
// Captures one adder-tree result per channel into the slots selected by
// in_enable (load or accumulate), closes the frame on in_last or when every
// slot has been written, then holds the frame until it is drained.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tlut_product_bank_if.slave (beat input, frame output, frame_cnt)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | collecting beats; in_ready=1, out_valid=0
// ST_FULL | frame complete and frozen; in_ready=0, out_valid=1 until drain
module tlut_product_bank #(
   parameter int DIM_C     = 4,
   parameter int DIM_A     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst,
   tlut_product_bank_if.slave   bus
);

   typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

   state_t                                     state;
   state_t                                     state_nxt;
   logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] slot;
   logic [DIM_A-1:0]                           filled;
   logic [CNT_WIDTH-1:0]                       frame_cnt;
   logic                                       in_ready;
   logic                                       out_valid;
   logic                                       accept;
   logic                                       drain;
   logic                                       frame_close;

   // A frame also closes when this beat completes the slot coverage.
   assign frame_close = bus.in_last | (&(filled | bus.in_enable));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_FILL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      drain     = 1'b0;
      case (state)
         ST_FILL: begin
            in_ready = ~rst;
            accept   = bus.in_valid & in_ready;
            if (accept && frame_close) state_nxt = ST_FULL;
         end
         ST_FULL: begin
            out_valid = 1'b1;
            drain     = bus.out_ready;
            if (drain) state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   // Accumulate only into slots already written this frame; the first write
   // to a slot always loads so stale data can never leak into a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot      <= '0;
         filled    <= '0;
         frame_cnt <= '0;
      end else if (drain) begin
         slot      <= '0;
         filled    <= '0;
         frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end else if (accept) begin
         for (int j = 0; j < DIM_A; j++) begin
            if (bus.in_enable[j]) begin
               for (int i = 0; i < DIM_C; i++) begin
                  if (filled[j] && bus.acc_mode)
                     slot[i][j] <= slot[i][j] + bus.in_data[i];
                  else
                     slot[i][j] <= bus.in_data[i];
               end
            end
         end
         filled <= filled | bus.in_enable;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = slot;
   assign bus.out_mask  = filled;
   assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_tlut_product_bank.sv
// Directed bench for tlut_product_bank with DIM_C=2, DIM_A=4, ACC_WIDTH=8
// and a 2-bit frame counter. Rows are compared as {slot3,slot2,slot1,slot0}.
module tb_tlut_product_bank;
   localparam int DC = 2;
   localparam int DA = 4;
   localparam int AW = 8;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   tlut_product_bank_if #(.DIM_C(DC), .DIM_A(DA), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   tlut_product_bank #(.DIM_C(DC), .DIM_A(DA), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [3:0] en;
      logic       last;
      logic       acc;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       ordy;
      logic       e_valid;
      logic       e_ready;
      logic [3:0] e_mask;
      logic [31:0] e_r0;
      logic [31:0] e_r1;
      logic [1:0] e_cnt;
   } vec_t;

   vec_t tv[21];

   function automatic vec_t mk(logic v, logic [3:0] en, logic last, logic acc,
                               logic [7:0] d0, logic [7:0] d1, logic ordy,
                               logic ev, logic er, logic [3:0] em,
                               logic [31:0] r0, logic [31:0] r1, logic [1:0] ec);
      vec_t t;
      t.valid = v;  t.en = en;  t.last = last;  t.acc = acc;
      t.d0 = d0;    t.d1 = d1;  t.ordy = ordy;
      t.e_valid = ev; t.e_ready = er; t.e_mask = em;
      t.e_r0 = r0;  t.e_r1 = r1; t.e_cnt = ec;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic er,
                            input logic [3:0] em, input logic [31:0] r0,
                            input logic [31:0] r1, input logic [1:0] ec);
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
      chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(er));
      chk({tag, ".out_mask"},  64'(bus.out_mask),  64'(em));
      chk({tag, ".row0"},      64'(bus.out_data[0]), 64'(r0));
      chk({tag, ".row1"},      64'(bus.out_data[1]), 64'(r1));
      chk({tag, ".frame_cnt"}, 64'(bus.frame_cnt), 64'(ec));
   endtask

   task automatic drive(input logic v, input logic [3:0] en, input logic last,
                        input logic acc, input logic [7:0] d0, input logic [7:0] d1,
                        input logic ordy);
      bus.in_valid   = v;
      bus.in_enable  = en;
      bus.in_last    = last;
      bus.acc_mode   = acc;
      bus.in_data[0] = d0;
      bus.in_data[1] = d1;
      bus.out_ready  = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] wrap_exp[5];
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

      //            v  en      last acc d0   d1   ordy  ev er  mask     row0          row1          cnt
      tv[0]  = mk(1, 4'b0001, 0, 0, 8'd1,  8'd2,  0,  0, 1, 4'b0001, 32'h00000001, 32'h00000002, 0);
      tv[1]  = mk(1, 4'b0010, 0, 0, 8'd3,  8'd4,  0,  0, 1, 4'b0011, 32'h00000301, 32'h00000402, 0);
      tv[2]  = mk(1, 4'b0100, 0, 0, 8'd5,  8'd6,  0,  0, 1, 4'b0111, 32'h00050301, 32'h00060402, 0);
      tv[3]  = mk(1, 4'b1000, 0, 0, 8'd7,  8'd8,  0,  1, 0, 4'b1111, 32'h07050301, 32'h08060402, 0);
      tv[4]  = mk(1, 4'b0001, 0, 0, 8'd99, 8'd99, 0,  1, 0, 4'b1111, 32'h07050301, 32'h08060402, 0);
      tv[5]  = mk(0, 4'b0000, 0, 0, 8'd0,  8'd0,  1,  0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1);
      tv[6]  = mk(1, 4'b0001, 0, 1, 8'd200,8'd10, 0,  0, 1, 4'b0001, 32'h000000C8, 32'h0000000A, 1);
      tv[7]  = mk(1, 4'b0001, 0, 1, 8'd100,8'd20, 0,  0, 1, 4'b0001, 32'h0000002C, 32'h0000001E, 1);
      tv[8]  = mk(1, 4'b0001, 1, 1, 8'd1,  8'd30, 0,  1, 0, 4'b0001, 32'h0000002D, 32'h0000003C, 1);
      tv[9]  = mk(0, 4'b0000, 0, 0, 8'd0,  8'd0,  1,  0, 1, 4'b0000, 32'h00000000, 32'h00000000, 2);
      tv[10] = mk(1, 4'b0110, 1, 0, 8'd9,  8'd9,  0,  1, 0, 4'b0110, 32'h00090900, 32'h00090900, 2);
      tv[11] = mk(0, 4'b0000, 0, 0, 8'd0,  8'd0,  1,  0, 1, 4'b0000, 32'h00000000, 32'h00000000, 3);
      tv[12] = mk(1, 4'b0000, 1, 0, 8'd5,  8'd5,  0,  1, 0, 4'b0000, 32'h00000000, 32'h00000000, 3);
      tv[13] = mk(0, 4'b0000, 0, 0, 8'd0,  8'd0,  1,  0, 1, 4'b0000, 32'h00000000, 32'h00000000, 0);
      tv[14] = mk(1, 4'b0011, 0, 0, 8'd4,  8'd5,  0,  0, 1, 4'b0011, 32'h00000404, 32'h00000505, 0);
      tv[15] = mk(1, 4'b0010, 0, 0, 8'd7,  8'd1,  0,  0, 1, 4'b0011, 32'h00000704, 32'h00000105, 0);
      tv[16] = mk(1, 4'b0001, 0, 1, 8'd1,  8'd1,  0,  0, 1, 4'b0011, 32'h00000705, 32'h00000106, 0);
      tv[17] = mk(1, 4'b1100, 0, 1, 8'd2,  8'd3,  0,  1, 0, 4'b1111, 32'h02020705, 32'h03030106, 0);
      tv[18] = mk(1, 4'b1111, 0, 1, 8'd50, 8'd50, 1,  0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1);
      tv[19] = mk(1, 4'b1111, 0, 1, 8'd50, 8'd50, 0,  1, 0, 4'b1111, 32'h32323232, 32'h32323232, 1);
      tv[20] = mk(0, 4'b0000, 0, 0, 8'd0,  8'd0,  1,  0, 1, 4'b0000, 32'h00000000, 32'h00000000, 2);

      rst = 1'b1;
      drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 4'b0000, 32'h0, 32'h0, 0);
      rst = 1'b0;
      #1;
      chk("release.in_ready", 64'(bus.in_ready), 64'd1);

      for (int i = 0; i < 21; i++) begin
         drive(tv[i].valid, tv[i].en, tv[i].last, tv[i].acc, tv[i].d0, tv[i].d1, tv[i].ordy);
         step();
         check_all($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_ready, tv[i].e_mask,
                   tv[i].e_r0, tv[i].e_r1, tv[i].e_cnt);
      end

      // Backpressure: a held beat is ignored while FULL, then loads after the drain.
      drive(1, 4'b0101, 1, 0, 8'd11, 8'd12, 0);
      step();
      check_all("bp.close", 1, 0, 4'b0101, 32'h000B000B, 32'h000C000C, 2);
      drive(1, 4'b1111, 0, 1, 8'd77, 8'd88, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check_all($sformatf("bp.hold%0d", k), 1, 0, 4'b0101, 32'h000B000B, 32'h000C000C, 2);
      end
      bus.out_ready = 1'b1;
      step();
      check_all("bp.drain", 0, 1, 4'b0000, 32'h0, 32'h0, 3);
      bus.out_ready = 1'b0;
      step();
      check_all("bp.load", 1, 0, 4'b1111, 32'h4D4D4D4D, 32'h58585858, 3);
      drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 1);
      step();
      check_all("bp.drain2", 0, 1, 4'b0000, 32'h0, 32'h0, 0);

      // One more frame so the counter is non-zero before the reset tests.
      drive(1, 4'b0001, 1, 0, 8'd6, 8'd6, 0);
      step();
      drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 1);
      step();
      chk("pre_rst.frame_cnt", 64'(bus.frame_cnt), 64'd1);

      // Asynchronous reset mid-frame.
      drive(1, 4'b0001, 0, 0, 8'd1, 8'd2, 0);
      step();
      drive(1, 4'b0010, 0, 0, 8'd3, 8'd4, 0);
      step();
      drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("rst_mid", 0, 0, 4'b0000, 32'h0, 32'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 4'b0100, 1, 1, 8'd3, 8'd3, 0);
      step();
      check_all("post_rst", 1, 0, 4'b0100, 32'h00030000, 32'h00030000, 0);

      // Asynchronous reset while FULL.
      drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("rst_full", 0, 0, 4'b0000, 32'h0, 32'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Counter wrap with a 2-bit frame counter.
      for (int k = 0; k < 5; k++) begin
         drive(1, 4'b0001, 1, 0, 8'(k + 1), 8'(k + 1), 0);
         step();
         chk($sformatf("wrap%0d.out_valid", k), 64'(bus.out_valid), 64'd1);
         drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 1);
         step();
         chk($sformatf("wrap%0d.frame_cnt", k), 64'(bus.frame_cnt), 64'(wrap_exp[k]));
      end
      drive(0, 4'b0000, 0, 0, 8'd0, 8'd0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tlut_product_bank.md
# tlut_product_bank

Parametrised product capture bank for the temporal-LUT multiplier datapath: captures per-channel adder-tree results into a `DIM_C x DIM_A` matrix of slots, selected per beat by a slot-enable mask. Adds overwrite or accumulate modes, frame completion tracking and a valid/ready drain handshake. It sits between the adder trees and the downstream output/requantisation stage. The bank holds a completed frame until it is drained, applying backpressure upstream meanwhile.

## Interface
- `DIM_C`, default 4: number of channels (rows).
- `DIM_A`, default 8: number of slots per channel (columns).
- `ACC_WIDTH`, default 16: width of each slot and input value.
- `CNT_WIDTH`, default 16: width of the frame counter.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  bank accepts beats.
- `in_data`  in  `[DIM_C][ACC_WIDTH]`  one value per channel.
- `in_enable`  in  `DIM_A`  slot-write mask; any pattern, including zero, is legal.
- `in_last`  in  1  this beat closes the frame.
- `acc_mode`  in  1  0 = load, 1 = accumulate; sampled per beat.
- `out_valid`  out  1  completed frame presented.
- `out_ready`  in  1  downstream takes the frame.
- `out_data`  out  `[DIM_C][DIM_A][ACC_WIDTH]`  slot matrix, driven directly from the registers.
- `out_mask`  out  `DIM_A`  slots written in this frame.
- `frame_cnt`  out  `CNT_WIDTH`  number of drained frames; wraps.

## Operation
- **States**
  - FILL: `in_ready=1`, `out_valid=0`.
  - FULL: `in_ready=0`, `out_valid=1`.
- **Accept.** A beat is accepted when `in_valid & in_ready`. Nothing else changes slot state.
- **Slot write.** On an accepted beat, for every channel `i` and every slot `j` with `in_enable[j]=1`:
  - If `filled[j]=0` or `acc_mode=0`: `slot[i][j] <= in_data[i]` (load).
  - Otherwise: `slot[i][j] <= slot[i][j] + in_data[i]`, mod 2^`ACC_WIDTH`. Unsigned, wraps, no saturation, no flag.
  - Set `filled[j]`.
- **Slot hold.** Slots with `in_enable[j]=0` hold their value.
- **Frame close.** The frame closes on an accepted beat when `in_last=1`, or when `filled | in_enable` becomes all ones. The state moves FILL to FULL at that edge.
- **Empty frame.** `in_last` with an all-zero `in_enable` and `filled=0` closes an empty frame: `out_mask=0`, all data 0.
- **FULL.** Slots, `filled` and `out_mask` are frozen.
- **Drain.** When `out_valid & out_ready`: all slots are cleared to 0, `filled` is cleared, `frame_cnt` is incremented, and the state returns to FILL. Unwritten slots therefore always read 0.
- **Output mask.** `out_mask = filled` in both states. It is a valid qualifier only while `out_valid=1`.
- **Reset.**
  - Reset asserted mid-frame or mid-drain discards the partial frame.
  - While `rst=1`: all slots 0, `filled=0`, state FILL, `frame_cnt=0`, `out_valid=0`, `in_ready=0`, `out_mask=0`.
- **Deadlock freedom.** `in_ready` does not depend on `in_valid`, and `out_valid` does not depend on `out_ready`.

## Timing
- Write latency: a beat accepted in cycle t is visible on `out_data` in cycle t+1.
- Close-to-valid: a closing beat in cycle t gives `out_valid=1` and `in_ready=0` in cycle t+1.
- Drain: a handshake in cycle t gives FILL with cleared slots in cycle t+1. `in_ready=1` from t+1, so the next beat can be accepted in t+1.
- Minimum frame period: 2 cycles (one closing beat, then the drain cycle, with `out_ready` held high).
- Back-to-back beats are accepted every cycle while in FILL.
- `out_valid` stays high and `out_data` stays stable until the handshake.
- `in_valid` during FULL is ignored. The upstream must hold the beat until `in_ready=1`.
- There are no combinational paths from inputs to outputs except through registers. `in_ready` and `out_valid` are decoded from state; `in_ready` is also gated by `rst`.

## Test plan
All scenarios use `DIM_C=2`, `DIM_A=4`, `ACC_WIDTH=8`.
1. **Reset, then a full frame by single-slot writes.** Reset, then beats with enable 0001/0010/0100/1000 and data {1,2},{3,4},{5,6},{7,8}, `in_last=0`.
   - `out_valid` rises the cycle after the 4th beat.
   - `out_mask=1111`.
   - `out_data` row0 = 1,3,5,7; row1 = 2,4,6,8.
   - `in_ready=0` until the drain.
2. **Accumulate with wrap.** `acc_mode=1`, slot 0 written three times with {200,10},{100,20},{1,30}, then `in_last` on the third beat.
   - `slot[0][0]=45` (301 mod 256); `slot[1][0]=60`.
   - `out_mask=0001`; other slots read 0.
3. **Early close, empty frame, multi-hot enable.**
   - Enable 0110 with {9,9} and `in_last=1`: `out_mask=0110`, slots 1 and 2 read 9, slots 0 and 3 read 0.
   - Next, enable 0000 with `in_last=1`: an empty frame with `out_mask=0` and all data 0.
4. **Backpressure.** Hold `out_ready=0` for 5 cycles with `in_valid=1` and new data.
   - Output is stable; no beat is accepted.
   - Raise `out_ready`: `frame_cnt` increments once, the pending beat is accepted in the next cycle, and it loads (not adds) even with `acc_mode=1`.
5. **Reset mid-operation.**
   - Assert `rst` asynchronously after 2 beats of a frame: all outputs return to reset values immediately.
   - After release, a fresh frame sees no residue from the discarded beats.
   - Assert `rst` during FULL: `out_valid` drops at once and `frame_cnt` stays 0.
6. **Counter wrap.** With `CNT_WIDTH=2`, drain 5 frames: `frame_cnt` reads 1,2,3,0,1.
